mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter ITER, default WIDTH, number of iteration cycles per operation.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset is asserted when the port is low.
REQ-005 start  input  1  request pulse from control (HILOWrite path); sampled only in IDLE.
REQ-006 op  input  1  operation select: 0 = MULT (signed), 1 = DIV (signed).
REQ-007 A  input  WIDTH  operand A (multiplicand or dividend), captured when start is accepted.
REQ-008 B  input  WIDTH  operand B (multiplier or divisor), captured when start is accepted.
REQ-009 HI  output  WIDTH  MULT: upper product word; DIV: remainder.
REQ-010 LO  output  WIDTH  MULT: lower product word; DIV: quotient.
REQ-011 busy  output  1  high while an operation is in progress (CALC, FIX, DONE).
REQ-012 done  output  1  one-cycle pulse; HI and LO are valid for the completed operation.
REQ-013 Div0  output  1  one-cycle pulse on a DIV request with B == 0.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, CALC, FIX, DONE, DZERO.
REQ-015 IDLE, start=1, op=DIV, B==0 -> DZERO; DZERO -> IDLE next edge; Div0=1 only in DZERO; HI, LO unchanged; busy stays 0.
REQ-016 IDLE, start=1, any other case -> CALC; A, B and op SHALL be latched and the iteration counter cleared on that edge.
REQ-017 CALC SHALL run exactly ITER cycles: one radix-2 Booth step (MULT) or one restoring step on operand magnitudes (DIV) per cycle; after the last step -> FIX.
REQ-018 FIX SHALL apply sign correction, write HI and LO on its exit edge, then -> DONE.
REQ-019 DONE SHALL drive done=1 for exactly one cycle, then -> IDLE.
REQ-020 Latency: start sampled at edge N; HI and LO updated at edge N+ITER+1; done high between edges N+ITER+1 and N+ITER+2.
REQ-021 MULT SHALL produce the full 2*WIDTH-bit two's-complement product {HI,LO} of signed A*B.
REQ-022 DIV SHALL truncate toward zero; the remainder SHALL take the sign of the dividend; A = LO*B + HI always holds.
REQ-023 DIV of -2^(WIDTH-1) by -1 SHALL give LO=0x80000000 and HI=0, with no flag raised.
REQ-024 start while busy=1 SHALL be ignored; no queuing, and latched operands SHALL NOT change.
REQ-025 A, B and op SHALL be don't-care after acceptance; results SHALL depend only on the latched values.
REQ-026 HI and LO SHALL hold their last values until the next FIX exit; DZERO and ignored starts SHALL NOT alter them.
REQ-027 A new start in the same cycle as done SHALL be ignored; the earliest accepted start is the cycle after DONE (IDLE).

Reset
REQ-028 reset low SHALL immediately force IDLE, HI=0, LO=0, busy=0, done=0, Div0=0, counter=0, and clear the latched operands, independent of clock.
REQ-029 Reset asserted mid-operation SHALL abort the operation without producing a done or Div0 pulse.
REQ-030 After reset deassertion, the first start SHALL be accepted on the first rising edge at which it is high.

Structure
REQ-031 Package mult_div_pkg SHALL hold the state encoding (IDLE, CALC, FIX, DONE, DZERO), the op encoding (OP_MULT=0, OP_DIV=1) and the defaults WIDTH=32 and ITER=32.
REQ-032 One combinational sub-module, md_sign_fix, SHALL perform the final two's-complement correction of quotient, remainder and product; the iteration datapath stays in mult_div_unit.

Verification
REQ-033 MULT A=7, B=-3, start at edge N -> done at N+33, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-034 DIV A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
REQ-035 DIV A=5, B=0 -> Div0 high exactly one cycle after start, busy never high, HI and LO keep their previous MULT result.
REQ-036 MULT A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0; a second start pulsed at cycles N+5 and N+33 is ignored with no extra done.
REQ-037 Reset pulled low at cycle N+10 of a DIV -> busy=0 and HI=LO=0 immediately; no done; a new MULT 3*4 afterwards -> LO=12, HI=0.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared types and defaults for the signed multiply/divide unit.
// Imported by the interface, the top and the sign-fix stage.
package mult_div_pkg;

   localparam int MD_WIDTH = 32;
   localparam int MD_ITER  = 32;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      FIX,
      DONE,
      DZERO
   } state_e;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } op_e;

endpackage

// File: rtl/mult_div_if.sv
// Request/result bundle between control (HILOWrite path) and the
// multiply/divide unit.
interface mult_div_if
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
);

   logic             start;
   logic             op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
   logic             busy;
   logic             done;
   logic             Div0;

   modport master (
      output start, op, A, B,
      input  HI, LO, busy, done, Div0
   );

   modport slave (
      input  start, op, A, B,
      output HI, LO, busy, done, Div0
   );

endinterface

// File: rtl/md_sign_fix.sv
// Final two's-complement correction of the raw iteration results.
// Booth already yields a signed product, so MULT passes straight through.
module md_sign_fix
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  op_e              op_i,
   input  logic             a_neg_i,
   input  logic             b_neg_i,
   input  logic [WIDTH-1:0] hi_raw_i,
   input  logic [WIDTH-1:0] lo_raw_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   always_comb begin
      hi_o = hi_raw_i;
      lo_o = lo_raw_i;
      if (op_i == OP_DIV) begin
         // quotient negative on sign mismatch, remainder follows dividend
         if (a_neg_i ^ b_neg_i) lo_o = -lo_raw_i;
         if (a_neg_i)           hi_o = -hi_raw_i;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring on magnitudes)
// with HI/LO result registers.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int ITER  = WIDTH
) (
   input  logic       clock,
   input  logic       reset,
   mult_div_if.slave  md
);

   localparam int CW = $clog2(ITER + 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q;
   op_e              op_q;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             qm1_q, qm1_d;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [WIDTH-1:0] hi_fix, lo_fix;

   logic             div0_req;
   logic             accept;
   logic             last;
   logic [WIDTH-1:0] a_in_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   mcand, bsum, rsh, rdiff;

   assign div0_req = md.start && (md.op == OP_DIV) && (md.B == '0);
   assign accept   = md.start && !div0_req;
   assign last     = (cnt_q == CW'(ITER - 1));

   assign a_in_mag = md.A[WIDTH-1] ? -md.A : md.A;
   assign b_mag    = b_q[WIDTH-1] ? -b_q : b_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (div0_req)    state_d = DZERO;
            else if (accept) state_d = CALC;
         end
         CALC:    if (last) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         DZERO:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      md.busy = 1'b0;
      md.done = 1'b0;
      md.Div0 = 1'b0;
      case (state_q)
         CALC, FIX: md.busy = 1'b1;
         DONE: begin
            md.busy = 1'b1;
            md.done = 1'b1;
         end
         DZERO:   md.Div0 = 1'b1;
         default: ;
      endcase
   end

   assign md.HI = hi_q;
   assign md.LO = lo_q;

   // Booth: acc is one bit wider so -2^(W-1) multiplicands cannot overflow
   assign mcand = {b_q[WIDTH-1], b_q};

   always_comb begin
      bsum = acc_q;
      case ({q_q[0], qm1_q})
         2'b01:   bsum = acc_q + mcand;
         2'b10:   bsum = acc_q - mcand;
         default: ;
      endcase
   end

   assign rsh   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign rdiff = rsh - {1'b0, b_mag};

   always_comb begin
      acc_d = acc_q;
      q_d   = q_q;
      qm1_d = 1'b0;
      if (op_q == OP_MULT) begin
         acc_d = {bsum[WIDTH], bsum[WIDTH:1]};
         q_d   = {bsum[0], q_q[WIDTH-1:1]};
         qm1_d = q_q[0];
      end else if (!rdiff[WIDTH]) begin
         acc_d = rdiff;
         q_d   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_d = rsh;
         q_d   = {q_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= OP_MULT;
         acc_q <= '0;
         q_q   <= '0;
         qm1_q <= 1'b0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q   <= md.A;
                  b_q   <= md.B;
                  op_q  <= op_e'(md.op);
                  cnt_q <= '0;
                  acc_q <= '0;
                  q_q   <= (md.op == OP_DIV) ? a_in_mag : md.A;
                  qm1_q <= 1'b0;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               q_q   <= q_d;
               qm1_q <= qm1_d;
               cnt_q <= cnt_q + CW'(1);
            end
            FIX: begin
               hi_q <= hi_fix;
               lo_q <= lo_fix;
            end
            default: ;
         endcase
      end
   end

   md_sign_fix #(
      .WIDTH (WIDTH)
   ) u_fix (
      .op_i     (op_q),
      .a_neg_i  (a_q[WIDTH-1]),
      .b_neg_i  (b_q[WIDTH-1]),
      .hi_raw_i (acc_q[WIDTH-1:0]),
      .lo_raw_i (q_q),
      .hi_o     (hi_fix),
      .lo_o     (lo_fix)
   );

endmodule
